// File: rtl/bcd_pkg.sv
// bcd_pkg: shared widths, types and BCD helper functions for the modulo counter.
// Rev 1.0 - initial release.
`default_nettype none

package bcd_pkg;

  localparam int BCD_W      = 4;
  localparam int MAX_DIGITS = 6;
  localparam int MAX_W      = BCD_W * MAX_DIGITS;

  typedef logic [BCD_W-1:0] nibble_t;
  typedef logic [MAX_W-1:0] bcd_vec_t;

  // Digits above 'digits' are left at zero so callers can truncate freely.
  function automatic bcd_vec_t to_bcd(input integer value, input integer digits);
    bcd_vec_t r;
    integer   v;
    r = '0;
    v = value;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (i < digits) begin
        r[i*BCD_W +: BCD_W] = nibble_t'(v % 10);
      end
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic is_bcd(input bcd_vec_t v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (v[i*BCD_W +: BCD_W] > 4'd9) begin
        ok = 1'b0;
      end
    end
    return ok;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_digit.sv
// bcd_digit: one BCD decade with set, increment (9 -> 0) and decrement (0 -> 9).
// Rev 1.0 - initial release.
`default_nettype none

module bcd_digit
  import bcd_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  input  logic             set_en,
  input  logic [BCD_W-1:0] set_val,
  output logic [BCD_W-1:0] q,
  output logic             at9,
  output logic             at0
);

  logic [BCD_W-1:0] q_q;
  logic [BCD_W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (set_en) begin
      q_d = set_val;
    end else if (inc) begin
      q_d = (q_q == 4'd9) ? 4'd0 : q_q + 4'd1;
    end else if (dec) begin
      q_d = (q_q == 4'd0) ? 4'd9 : q_q - 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q   = q_q;
  assign at9 = (q_q == 4'd9);
  assign at0 = (q_q == 4'd0);

endmodule

`default_nettype wire

// File: rtl/bcd_mod_counter.sv
// bcd_mod_counter: multi-digit BCD up/down modulo-N counter with clear, validated load
// and cascade-ready carry/borrow.  Rev 1.0 - initial release.
`default_nettype none

module bcd_mod_counter
  import bcd_pkg::*;
#(
  parameter int DIGITS  = 2,
  parameter int MODULUS = 60
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                up,
  input  logic                clr,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  output logic [4*DIGITS-1:0] dout,
  output logic                co,
  output logic                bo,
  output logic                load_err
);

  localparam int           W           = BCD_W * DIGITS;
  localparam bcd_vec_t     TERM_UP_EXT = to_bcd(MODULUS - 1, DIGITS);
  localparam logic [W-1:0] TERM_UP     = TERM_UP_EXT[W-1:0];

  if (DIGITS < 1 || DIGITS > MAX_DIGITS || MODULUS < 2 || MODULUS > 10**DIGITS) begin : g_param_check
    $error("bcd_mod_counter: DIGITS must be 1..6 and MODULUS 2..10**DIGITS");
  end

  logic [DIGITS-1:0] w_at9;
  logic [DIGITS-1:0] w_at0;
  logic [DIGITS-1:0] w_inc;
  logic [DIGITS-1:0] w_dec;
  logic [W-1:0]      w_q;
  logic [W-1:0]      w_set_val;
  logic              w_set_en;
  bcd_vec_t          w_q_ext;
  bcd_vec_t          w_lv_ext;
  logic              w_q_legal;
  logic              w_lv_valid;
  logic              w_at_term;
  logic              w_at_zero;
  logic              w_step_up;
  logic              w_step_dn;
  logic              load_err_q;
  logic              load_err_d;

  assign w_q_ext    = bcd_vec_t'(w_q);
  assign w_lv_ext   = bcd_vec_t'(load_val);
  // For valid BCD the numeric ordering of the packed vector matches decimal ordering.
  assign w_q_legal  = is_bcd(w_q_ext) && (w_q <= TERM_UP);
  assign w_lv_valid = is_bcd(w_lv_ext) && (load_val <= TERM_UP);
  assign w_at_term  = (w_q == TERM_UP);
  assign w_at_zero  = (w_q == '0);
  assign w_step_up  = en & up & ~clr & ~load;
  assign w_step_dn  = en & ~up & ~clr & ~load;

  always_comb begin
    logic chain9;
    logic chain0;
    w_set_en   = 1'b0;
    w_set_val  = '0;
    w_inc      = '0;
    w_dec      = '0;
    load_err_d = 1'b0;
    chain9     = 1'b1;
    chain0     = 1'b1;
    if (clr) begin
      w_set_en = 1'b1;
    end else if (load) begin
      if (w_lv_valid) begin
        w_set_en  = 1'b1;
        w_set_val = load_val;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (w_step_up) begin
      // Wrap and corrupted-state recovery both force every digit to zero.
      if (w_at_term || !w_q_legal) begin
        w_set_en = 1'b1;
      end else begin
        for (int i = 0; i < DIGITS; i++) begin
          w_inc[i] = chain9;
          chain9   = chain9 & w_at9[i];
        end
      end
    end else if (w_step_dn) begin
      if (w_at_zero || !w_q_legal) begin
        w_set_en  = 1'b1;
        w_set_val = TERM_UP;
      end else begin
        for (int i = 0; i < DIGITS; i++) begin
          w_dec[i] = chain0;
          chain0   = chain0 & w_at0[i];
        end
      end
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .clk     (clk),
      .rst     (rst),
      .inc     (w_inc[g]),
      .dec     (w_dec[g]),
      .set_en  (w_set_en),
      .set_val (w_set_val[g*BCD_W +: BCD_W]),
      .q       (w_q[g*BCD_W +: BCD_W]),
      .at9     (w_at9[g]),
      .at0     (w_at0[g])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_err_q <= 1'b0;
    end else begin
      load_err_q <= load_err_d;
    end
  end

  assign dout     = w_q;
  assign co       = w_step_up & w_at_term;
  assign bo       = w_step_dn & w_at_zero;
  assign load_err = load_err_q;

endmodule

`default_nettype wire
